// File: rtl/param_memory_pkg.sv
// Shared FSM encoding and elaboration limits for the parametrised single-port memory.
package param_memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 4;

  function automatic bit latency_legal(input int unsigned lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/param_memory_if.sv
// Request/response handshake between the CPU side and param_memory.
interface param_memory_if #(
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  read_en;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] address;
  logic                  ready;
  logic                  rd_valid;
  logic                  err;

  modport master (
    output read_en, write_en, address,
    input  ready, rd_valid, err
  );

  modport slave (
    input  read_en, write_en, address,
    output ready, rd_valid, err
  );

endinterface

// File: rtl/param_memory_read_pipe.sv
// Fixed-depth valid/data shift register that delays launched reads to the bus slot.
module param_memory_read_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [LATENCY-1:0]    valid_q;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  // Reset flushes in-flight reads so an aborted read never reaches the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < int'(LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/param_memory.sv
// Parametrised single-port data/instruction memory on a shared tristate data bus,
// with reset-time array clear, ready indication and a pipelined read path.
module param_memory
  import param_memory_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 5,
  parameter int unsigned           DEPTH        = 32,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  param_memory_if.slave         bus,
  inout  wire  [DATA_WIDTH-1:0] data_bus
);

  localparam int unsigned          PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] DEPTH_W   = PTR_WIDTH'(DEPTH);

  if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
    $error("param_memory: READ_LATENCY outside legal range");
  end
  if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_WIDTH))) begin : g_bad_depth
    $error("param_memory: DEPTH does not fit ADDR_WIDTH");
  end

  state_e                state_q, state_d;
  logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  launch_q, launch_d;
  logic [DATA_WIDTH-1:0] launch_data_q, launch_data_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  addr_ok;
  logic                  any_req;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;

  assign addr_ok = ({1'b0, bus.address} < DEPTH_W);
  assign any_req = bus.read_en | bus.write_en;

  // Next-state, request arbitration and array write port.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    ready_d       = ready_q;
    err_d         = 1'b0;
    launch_d      = 1'b0;
    launch_data_d = launch_data_q;
    mem_we        = 1'b0;
    mem_waddr     = bus.address;
    mem_wdata     = data_bus;
    rd_ok         = 1'b0;
    wr_ok         = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q[ADDR_WIDTH-1:0];
        mem_wdata = CLEAR_VALUE;
        ptr_d     = ptr_q + PTR_WIDTH'(1);
        err_d     = any_req;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        // Read wins over write; a write is also refused while the bus carries read data.
        rd_ok  = bus.read_en & addr_ok;
        wr_ok  = bus.write_en & ~bus.read_en & addr_ok & ~pipe_valid;
        err_d  = (bus.read_en & ~addr_ok) | (bus.write_en & ~wr_ok);
        mem_we = wr_ok;
        launch_d = rd_ok;
        if (rd_ok) begin
          launch_data_d = mem_q[bus.address];
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Control registers; reset restarts the clear sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      ptr_q         <= '0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      launch_q      <= 1'b0;
      launch_data_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
      launch_q      <= launch_d;
      launch_data_q <= launch_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  param_memory_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (launch_q),
    .data_i  (launch_data_q),
    .valid_o (pipe_valid),
    .data_o  (pipe_data)
  );

  assign data_bus     = pipe_valid ? pipe_data : {DATA_WIDTH{1'bz}};
  assign bus.ready    = ready_q;
  assign bus.rd_valid = pipe_valid;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: three instances cover latency 1/3/2, full and partial depth.
module tb_param_memory;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned N_DUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_v    [N_DUT];
  logic          req_rd   [N_DUT];
  logic          req_wr   [N_DUT];
  logic [AW-1:0] req_addr [N_DUT];
  logic          drv_en   [N_DUT];
  logic [DW-1:0] drv_dat  [N_DUT];

  wire [DW-1:0] bus_a;
  wire [DW-1:0] bus_b;
  wire [DW-1:0] bus_c;

  param_memory_if #(.ADDR_WIDTH(AW)) if_a ();
  param_memory_if #(.ADDR_WIDTH(AW)) if_b ();
  param_memory_if #(.ADDR_WIDTH(AW)) if_c ();

  assign if_a.read_en  = req_rd[0];
  assign if_a.write_en = req_wr[0];
  assign if_a.address  = req_addr[0];
  assign if_b.read_en  = req_rd[1];
  assign if_b.write_en = req_wr[1];
  assign if_b.address  = req_addr[1];
  assign if_c.read_en  = req_rd[2];
  assign if_c.write_en = req_wr[2];
  assign if_c.address  = req_addr[2];

  assign bus_a = drv_en[0] ? drv_dat[0] : {DW{1'bz}};
  assign bus_b = drv_en[1] ? drv_dat[1] : {DW{1'bz}};
  assign bus_c = drv_en[2] ? drv_dat[2] : {DW{1'bz}};

  param_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32), .READ_LATENCY(1), .CLEAR_VALUE(8'h00)
  ) u_dut_a (
    .clk(clk), .rst(rst_v[0]), .bus(if_a), .data_bus(bus_a)
  );

  param_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32), .READ_LATENCY(3), .CLEAR_VALUE(8'h00)
  ) u_dut_b (
    .clk(clk), .rst(rst_v[1]), .bus(if_b), .data_bus(bus_b)
  );

  param_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(20), .READ_LATENCY(2), .CLEAR_VALUE(8'h5A)
  ) u_dut_c (
    .clk(clk), .rst(rst_v[2]), .bus(if_c), .data_bus(bus_c)
  );

  int n_checks;
  int n_fail;

  function automatic logic valid_of(input int d);
    case (d)
      0:       return if_a.rd_valid;
      1:       return if_b.rd_valid;
      default: return if_c.rd_valid;
    endcase
  endfunction

  function automatic logic ready_of(input int d);
    case (d)
      0:       return if_a.ready;
      1:       return if_b.ready;
      default: return if_c.ready;
    endcase
  endfunction

  function automatic logic err_of(input int d);
    case (d)
      0:       return if_a.err;
      1:       return if_b.err;
      default: return if_c.err;
    endcase
  endfunction

  function automatic logic [DW-1:0] bus_of(input int d);
    case (d)
      0:       return bus_a;
      1:       return bus_b;
      default: return bus_c;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v,
                            input logic drive, output logic e);
    req_wr[d]   = 1'b1;
    req_addr[d] = a;
    drv_en[d]   = drive;
    drv_dat[d]  = v;
    tick();
    req_wr[d] = 1'b0;
    drv_en[d] = 1'b0;
    e = err_of(d);
  endtask

  // Returns data, edges from sampling edge to rd_valid (8 = never), err after sampling, rd_valid one cycle after.
  task automatic read_word(input int d, input logic [AW-1:0] a, output logic [DW-1:0] q,
                           output int lat, output logic e, output logic vafter);
    req_rd[d]   = 1'b1;
    req_addr[d] = a;
    tick();
    req_rd[d] = 1'b0;
    e   = err_of(d);
    lat = 0;
    while (!valid_of(d) && lat < 8) begin
      tick();
      lat++;
    end
    q = bus_of(d);
    tick();
    vafter = valid_of(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q;
    int            lat;
    logic          e;
    logic          va;
    int            k;
    logic          saw;
    int            first [N_DUT];

    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < int'(N_DUT); d++) begin
      rst_v[d]    = 1'b1;
      req_rd[d]   = 1'b0;
      req_wr[d]   = 1'b0;
      req_addr[d] = '0;
      drv_en[d]   = 1'b0;
      drv_dat[d]  = '0;
      first[d]    = -1;
    end

    tick();
    tick();
    for (int d = 0; d < int'(N_DUT); d++) begin
      check($sformatf("rst_ready%0d", d), 32'(ready_of(d)), 32'd0);
      check($sformatf("rst_rdvalid%0d", d), 32'(valid_of(d)), 32'd0);
      check($sformatf("rst_err%0d", d), 32'(err_of(d)), 32'd0);
      rst_v[d] = 1'b0;
    end

    // Clear length: ready rises DEPTH cycles after reset release.
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < int'(N_DUT); d++) begin
        if (first[d] < 0 && ready_of(d)) first[d] = i;
      end
      tick();
    end
    check("clr_cycles_a", 32'(first[0]), 32'd32);
    check("clr_cycles_b", 32'(first[1]), 32'd32);
    check("clr_cycles_c", 32'(first[2]), 32'd20);

    for (int i = 0; i < 32; i++) begin
      read_word(0, AW'(i), q, lat, e, va);
      check($sformatf("a_clr_rd%0d", i), 32'(q), 32'h00);
    end

    // Write then read-after-write, latency 1.
    write_word(0, 5'd5, 8'hA5, 1'b1, e);
    check("a_wr5_err", 32'(e), 32'd0);
    read_word(0, 5'd5, q, lat, e, va);
    check("a_rd5_lat", 32'(lat), 32'd1);
    check("a_rd5_data", 32'(q), 32'hA5);
    check("a_rd5_err", 32'(e), 32'd0);
    check("a_rd5_single", 32'(va), 32'd0);

    // Write while read data is on the bus is dropped.
    req_rd[0]   = 1'b1;
    req_addr[0] = 5'd5;
    tick();
    req_rd[0] = 1'b0;
    tick();
    check("a_cont_valid", 32'(valid_of(0)), 32'd1);
    check("a_cont_data", 32'(bus_of(0)), 32'hA5);
    write_word(0, 5'd6, 8'h00, 1'b0, e);
    check("a_cont_err", 32'(e), 32'd1);
    tick();
    check("a_cont_err_pulse", 32'(err_of(0)), 32'd0);
    read_word(0, 5'd6, q, lat, e, va);
    check("a_cont_mem6", 32'(q), 32'h00);

    // Simultaneous read and write: read served, write dropped.
    write_word(0, 5'd7, 8'h11, 1'b1, e);
    req_rd[0]   = 1'b1;
    req_wr[0]   = 1'b1;
    req_addr[0] = 5'd7;
    drv_en[0]   = 1'b1;
    drv_dat[0]  = 8'h3C;
    tick();
    req_rd[0] = 1'b0;
    req_wr[0] = 1'b0;
    drv_en[0] = 1'b0;
    check("a_coll_err", 32'(err_of(0)), 32'd1);
    tick();
    check("a_coll_valid", 32'(valid_of(0)), 32'd1);
    check("a_coll_data", 32'(bus_of(0)), 32'h11);
    tick();
    read_word(0, 5'd7, q, lat, e, va);
    check("a_coll_mem7", 32'(q), 32'h11);

    // Latency 3, back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      write_word(1, AW'(i), DW'(16 + i), 1'b1, e);
    end
    for (int i = 0; i < 4; i++) begin
      req_rd[1]   = 1'b1;
      req_addr[1] = AW'(i);
      tick();
      if (i < 3) check($sformatf("b_pipe_early%0d", i), 32'(valid_of(1)), 32'd0);
    end
    req_rd[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_pipe_valid%0d", i), 32'(valid_of(1)), 32'd1);
      check($sformatf("b_pipe_data%0d", i), 32'(bus_of(1)), 32'(16 + i));
      tick();
    end
    check("b_pipe_end", 32'(valid_of(1)), 32'd0);

    // Out-of-range requests on the 20-deep instance.
    write_word(2, 5'd25, 8'hFF, 1'b1, e);
    check("c_oor_wr_err", 32'(e), 32'd1);
    check("c_oor_wr_novalid", 32'(valid_of(2)), 32'd0);
    tick();
    check("c_oor_err_pulse", 32'(err_of(2)), 32'd0);
    read_word(2, 5'd25, q, lat, e, va);
    check("c_oor_rd_err", 32'(e), 32'd1);
    check("c_oor_rd_novalid", 32'(lat), 32'd8);
    write_word(2, 5'd20, 8'h66, 1'b1, e);
    check("c_depth_wr_err", 32'(e), 32'd1);
    tick();
    write_word(2, 5'd19, 8'h77, 1'b1, e);
    check("c_last_wr_err", 32'(e), 32'd0);
    read_word(2, 5'd19, q, lat, e, va);
    check("c_last_lat", 32'(lat), 32'd2);
    check("c_last_data", 32'(q), 32'h77);
    read_word(2, 5'd9, q, lat, e, va);
    check("c_alias9", 32'(q), 32'h5A);

    // Reset during an in-flight read restarts the clear.
    write_word(2, 5'd3, 8'h33, 1'b1, e);
    req_rd[2]   = 1'b1;
    req_addr[2] = 5'd3;
    tick();
    req_rd[2] = 1'b0;
    rst_v[2]  = 1'b1;
    tick();
    rst_v[2] = 1'b0;
    check("c_mid_valid", 32'(valid_of(2)), 32'd0);
    check("c_mid_ready", 32'(ready_of(2)), 32'd0);
    check("c_mid_err", 32'(err_of(2)), 32'd0);
    k   = 0;
    saw = 1'b0;
    while (!ready_of(2) && k < 40) begin
      if (valid_of(2)) saw = 1'b1;
      if (k == 10) begin
        req_wr[2]   = 1'b1;
        req_addr[2] = 5'd2;
        drv_en[2]   = 1'b1;
        drv_dat[2]  = 8'h44;
      end else begin
        req_wr[2] = 1'b0;
        drv_en[2] = 1'b0;
      end
      tick();
      k++;
      if (k == 11) check("c_clr_wr_err", 32'(err_of(2)), 32'd1);
    end
    req_wr[2] = 1'b0;
    drv_en[2] = 1'b0;
    check("c_mid_clr_cycles", 32'(k), 32'd20);
    check("c_mid_no_valid", 32'(saw), 32'd0);
    for (int i = 0; i < 20; i++) begin
      read_word(2, AW'(i), q, lat, e, va);
      check($sformatf("c_reclr_rd%0d", i), 32'(q), 32'h5A);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
Parametrised single-port storage for data and instructions, on a shared bidirectional data bus.
- Generalises the 8-bit/5-bit-address memory in data width, depth and read latency.
- Adds a synchronous reset that clears the array, a ready indication, a read-valid strobe and a pipelined read path.
- Sits between the CPU controller/bus and the rest of the datapath; the CPU uses ready/rd_valid instead of fixed timing.

Parameters:
DATA_WIDTH, 8, data bus and word width in bits (>=1)
ADDR_WIDTH, 5, address width in bits (>=1)
DEPTH, 32, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, clock edges from read_en sampled to data valid on bus; legal 1..4
CLEAR_VALUE, 0, word written to every location during reset clear

Ports:
clk  input  1  system clock, posedge triggered
rst  input  1  synchronous active-high reset
read_en  input  1  read request, sampled at posedge
write_en  input  1  write request, sampled at posedge; data taken from data_bus same edge
address  input  ADDR_WIDTH  word address, sampled with read_en/write_en
data_bus  inout  DATA_WIDTH  driven by block only while rd_valid=1, else high-Z
ready  output  1  1 = array initialised, requests accepted
rd_valid  output  1  1 = data_bus carries read data this cycle
err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset: rst sampled high at a posedge -> state CLEAR, clear pointer=0, ready=0, rd_valid=0, err=0, read pipeline flushed, data_bus high-Z from that edge. rst mid-read or mid-clear aborts and restarts the clear from address 0.
- FSM states: CLEAR, IDLE.
- CLEAR: one location per clock, mem[ptr]<=CLEAR_VALUE, ptr++.
  - Write at ptr=DEPTH-1 -> IDLE; ready=1 from that edge.
  - Clear takes exactly DEPTH cycles after rst deasserts.
- IDLE: ready=1; serves requests until next rst.
- Request priority at a posedge in IDLE: read over write.
- read_en=1, address<DEPTH: word launched into the read pipeline.
  - rd_valid=1 and data driven for exactly one cycle, starting at the edge READ_LATENCY edges after the sampling edge.
  - Back-to-back reads accepted every cycle (fully pipelined); each produces its own rd_valid cycle in order.
- write_en=1, read_en=0, address<DEPTH, rd_valid=0: mem[address]<=data_bus at that edge.
  - Read-after-write to the same address on the next cycle returns the new data.
- Rejections: err=1 for the following cycle; no state change; any read already in the pipeline is unaffected.
  - read_en and write_en both 1: read served, write dropped.
  - Any request with address>=DEPTH: reads return no rd_valid; writes dropped.
  - write_en=1 while rd_valid=1: write dropped (bus contention).
  - Any request while ready=0.
- Data read is the array content at the sampling edge (read-before-write is not possible, as a single port serves one access per edge).
- No X ever driven onto data_bus; high-Z whenever rd_valid=0.
- Width rules: address is compared unsigned against DEPTH; the clear pointer is ADDR_WIDTH+1 bits wide to allow DEPTH=2**ADDR_WIDTH.

Decomposition:
- Shared package: FSM state encoding (ST_CLEAR, ST_IDLE) and the legal READ_LATENCY bounds constant for elaboration checks.
- One natural sub-module: read_pipe, a READ_LATENCY-deep valid/data shift register producing rd_valid and the bus-drive data.
- Array, FSM and tristate logic stay in param_memory.

Test Plan:
- Reset clear: assert rst 2 cycles, release -> ready=0 for exactly 32 cycles, then 1; reading all 32 addresses returns 8'h00.
- Write/read, READ_LATENCY=1: write 8'hA5 @5, next cycle read @5 -> rd_valid=1 and data_bus=8'hA5 one edge later, high-Z otherwise.
- Pipelined reads, READ_LATENCY=3: preload @0..3 = 8'h10..8'h13; read 0,1,2,3 on consecutive cycles -> rd_valid high 4 consecutive cycles starting 3 edges after first request, data 8'h10..8'h13 in order.
- Collision: read_en=write_en=1 @7 with bus 8'h3C, mem[7]=8'h11 -> data 8'h11 returned, err pulse, mem[7] still 8'h11.
- Out of range, DEPTH=20: write 8'hFF @25 -> err pulse, no rd_valid; read @25 -> err, no rd_valid; mem unchanged.
- Reset mid-operation: issue read with READ_LATENCY=2, assert rst on the next edge -> rd_valid never rises, bus high-Z, ready=0, full clear restarts and all words read back CLEAR_VALUE.
